// File: rtl/core_seq_pkg.sv
// Shared state encoding and inst bus field map for the core instruction sequencer.
// Field positions assume an 11-bit SRAM address and a 37-bit inst bus.
package core_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        W_RD,
        K_LD,
        K_WAIT,
        X_RD,
        EXEC,
        DRAIN,
        ACC,
        DONE
    } state_t;

    localparam int B_L0_RD    = 0;
    localparam int B_L0_WR    = 1;
    localparam int B_OFIFO_RD = 2;
    localparam int B_LOAD     = 5;
    localparam int B_EXEC     = 6;
    localparam int B_XMEM_A   = 7;
    localparam int B_XMEM_WEN = 18;
    localparam int B_XMEM_CEN = 19;
    localparam int B_PMEM_A   = 20;
    localparam int B_PMEM_WEN = 31;
    localparam int B_PMEM_CEN = 32;
    localparam int B_ACC      = 33;
    localparam int B_RELU     = 34;

    // Both SRAMs deselected with write disabled; every other bit low.
    localparam logic [36:0] IDLE_INST = 37'h1_800C_0000;

endpackage

// File: rtl/seq_sram_rd_wr.sv
// Read stream: len reads at base+i, plus a write strobe lagging each read by one cycle (len+1 cycles).
// No backpressure; the counter runs while en is high and clears whenever en drops.
module seq_sram_rd_wr #(
    parameter int ADDR_BW = 11,
    parameter int CNT_BW  = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [ADDR_BW-1:0] base,
    input  logic [CNT_BW-1:0]  len,
    output logic               rd,
    output logic               wr,
    output logic               last,
    output logic [ADDR_BW-1:0] addr
);

    localparam logic [CNT_BW-1:0] CNT_ONE = CNT_BW'(1);

    logic [CNT_BW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_ONE;
        end else begin
            cnt <= '0;
        end
    end

    assign rd   = en && (cnt < len);
    assign wr   = en && (cnt != '0);
    assign last = en && (cnt == len);
    // Address wraps silently at the SRAM depth.
    assign addr = base + cnt[ADDR_BW-1:0];

endmodule

// File: rtl/core_seq.sv
// Sequences weight load, execute, ofifo drain and optional accumulate; inst is registered one cycle behind the FSM.
// Drain pops the ofifo only while ofifo_valid is high and aborts with err after TIMEOUT consecutive idle cycles.
module core_seq
    import core_seq_pkg::*;
#(
    parameter int ROW     = 8,
    parameter int COL     = 8,
    parameter int ADDR_BW = 11,
    parameter int INST_BW = 37,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_BW-1:0] w_base,
    input  logic [ADDR_BW-1:0] x_base,
    input  logic [ADDR_BW-1:0] x_len,
    input  logic [ADDR_BW-1:0] p_base,
    input  logic               acc_en,
    input  logic               relu_en,
    input  logic               ofifo_valid,
    output logic [INST_BW-1:0] inst,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam int CNT_BW = ADDR_BW + 1;
    localparam int TO_BW  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_BW-1:0] CNT_ONE = CNT_BW'(1);
    localparam logic [CNT_BW-1:0] ROW_C   = CNT_BW'(ROW);
    localparam logic [CNT_BW-1:0] ROW_M1  = CNT_BW'(ROW - 1);
    localparam logic [CNT_BW-1:0] COL_M1  = CNT_BW'(COL - 1);
    localparam logic [TO_BW-1:0]  TO_ONE  = TO_BW'(1);
    localparam logic [TO_BW-1:0]  TO_M1   = TO_BW'(TIMEOUT - 1);

    state_t state, state_nxt;

    logic [ADDR_BW-1:0] w_base_q, x_base_q, x_len_q, p_base_q;
    logic               acc_en_q, relu_en_q;
    logic [CNT_BW-1:0]  cnt, rd_issued, k;
    logic               wr_pend;
    logic [TO_BW-1:0]   idle_cnt;
    logic               err_q;
    logic [INST_BW-1:0] inst_q, inst_nxt;
    logic               drain_rd, drain_wr, timeout;

    logic [CNT_BW-1:0]  xlen_ext, xlen_m1;
    logic               ss_en, ss_rd, ss_wr, ss_last;
    logic [ADDR_BW-1:0] ss_base, ss_addr;
    logic [CNT_BW-1:0]  ss_len;

    assign xlen_ext = {1'b0, x_len_q};
    assign xlen_m1  = xlen_ext - CNT_ONE;

    // One read stream shared by the weight load, activation load and accumulate pass.
    assign ss_en   = (state == W_RD) || (state == X_RD) || (state == ACC);
    assign ss_base = (state == W_RD) ? w_base_q : (state == X_RD) ? x_base_q : p_base_q;
    assign ss_len  = (state == W_RD) ? ROW_C : xlen_ext;

    seq_sram_rd_wr #(
        .ADDR_BW (ADDR_BW),
        .CNT_BW  (CNT_BW)
    ) u_stream (
        .clk   (clk),
        .reset (reset),
        .en    (ss_en),
        .base  (ss_base),
        .len   (ss_len),
        .rd    (ss_rd),
        .wr    (ss_wr),
        .last  (ss_last),
        .addr  (ss_addr)
    );

    always_comb begin
        state_nxt = state;
        inst_nxt  = IDLE_INST;
        drain_rd  = 1'b0;
        drain_wr  = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (x_len == '0) ? DONE : W_RD;
            end
            W_RD, X_RD: begin
                if (ss_rd) begin
                    inst_nxt[B_XMEM_CEN]              = 1'b0;
                    inst_nxt[B_XMEM_A +: ADDR_BW]     = ss_addr;
                end
                if (ss_wr) inst_nxt[B_L0_WR] = 1'b1;
                if (ss_last) state_nxt = (state == W_RD) ? K_LD : EXEC;
            end
            K_LD: begin
                inst_nxt[B_LOAD]  = 1'b1;
                inst_nxt[B_L0_RD] = 1'b1;
                if (cnt == ROW_M1) state_nxt = K_WAIT;
            end
            K_WAIT: begin
                if (cnt == COL_M1) state_nxt = X_RD;
            end
            EXEC: begin
                inst_nxt[B_EXEC]  = 1'b1;
                inst_nxt[B_L0_RD] = 1'b1;
                if (cnt == xlen_m1) state_nxt = DRAIN;
            end
            DRAIN: begin
                drain_rd = ofifo_valid && (rd_issued < xlen_ext);
                inst_nxt[B_OFIFO_RD] = drain_rd;
                // The word popped last cycle is on the ofifo output now.
                if (wr_pend) begin
                    drain_wr = 1'b1;
                    inst_nxt[B_PMEM_CEN]          = 1'b0;
                    inst_nxt[B_PMEM_WEN]          = 1'b0;
                    inst_nxt[B_PMEM_A +: ADDR_BW] = p_base_q + k[ADDR_BW-1:0];
                end
                if (wr_pend && (k == xlen_m1)) begin
                    state_nxt = acc_en_q ? ACC : DONE;
                end else if (!ofifo_valid && (idle_cnt == TO_M1)) begin
                    timeout   = 1'b1;
                    state_nxt = DONE;
                end
            end
            ACC: begin
                if (ss_rd) begin
                    inst_nxt[B_PMEM_CEN]          = 1'b0;
                    inst_nxt[B_PMEM_A +: ADDR_BW] = ss_addr;
                end
                if (ss_wr) begin
                    inst_nxt[B_ACC]  = 1'b1;
                    inst_nxt[B_RELU] = relu_en_q;
                end
                if (ss_last) state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            inst_q    <= IDLE_INST;
            cnt       <= '0;
            rd_issued <= '0;
            k         <= '0;
            wr_pend   <= 1'b0;
            idle_cnt  <= '0;
            err_q     <= 1'b0;
            w_base_q  <= '0;
            x_base_q  <= '0;
            x_len_q   <= '0;
            p_base_q  <= '0;
            acc_en_q  <= 1'b0;
            relu_en_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            inst_q <= inst_nxt;
            cnt    <= ((state_nxt != state) || (state == IDLE)) ? '0 : cnt + CNT_ONE;

            if ((state == IDLE) && start) begin
                w_base_q  <= w_base;
                x_base_q  <= x_base;
                x_len_q   <= x_len;
                p_base_q  <= p_base;
                acc_en_q  <= acc_en;
                relu_en_q <= relu_en;
                err_q     <= 1'b0;
            end else if (timeout) begin
                err_q <= 1'b1;
            end

            if (state == DRAIN) begin
                if (drain_rd) rd_issued <= rd_issued + CNT_ONE;
                if (drain_wr) k <= k + CNT_ONE;
                wr_pend  <= drain_rd;
                idle_cnt <= ofifo_valid ? '0 : idle_cnt + TO_ONE;
            end else begin
                rd_issued <= '0;
                k         <= '0;
                wr_pend   <= 1'b0;
                idle_cnt  <= '0;
            end
        end
    end

    assign inst = inst_q;
    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);
    assign err  = err_q;

endmodule
